// File: rtl/tetris_grid_builder_if.sv
// Handshake and frame-publish bundle between the lock/video side and the grid builder.
// The master drives the lock offer, falling-piece overlay and frame timing; the slave is the builder.
interface tetris_grid_builder_if #(
    parameter int COLS = 8,
    parameter int ROWS = 18
);
    localparam int GRID_W = COLS * ROWS;

    logic              lock_valid;
    logic [GRID_W-1:0] lock_mask;
    logic              lock_ready;
    logic [GRID_W-1:0] piece_mask;
    logic              frame_end;
    logic [GRID_W-1:0] data_swap;
    logic              draw_finish;
    logic              busy;
    logic [3:0]        lines_cleared;
    logic [15:0]       score;
    logic              game_over;

    modport master (
        output lock_valid, lock_mask, piece_mask, frame_end,
        input  lock_ready, data_swap, draw_finish, busy, lines_cleared, score, game_over
    );

    modport slave (
        input  lock_valid, lock_mask, piece_mask, frame_end,
        output lock_ready, data_swap, draw_finish, busy, lines_cleared, score, game_over
    );
endinterface

// File: rtl/tetris_grid_builder.sv
// Owns the committed playfield: merges locked pieces, removes full rows, scores, detects
// game over, and publishes playfield | falling piece to the storage stage at each frame end.
module tetris_grid_builder #(
    parameter int COLS = 8,
    parameter int ROWS = 18
) (
    input logic                 clk,
    input logic                 rst,
    tetris_grid_builder_if.slave bus
);
    localparam int GRID_W = COLS * ROWS;
    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(ROWS + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MERGE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [GRID_W-1:0] grid_q, grid_d;
    logic [GRID_W-1:0] mask_q, mask_d;
    logic [GRID_W-1:0] swap_q, swap_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     clr_q, clr_d;
    logic [3:0]        lines_q, lines_d;
    logic [15:0]       score_q, score_d;
    logic              go_q, go_d;
    logic              df_q, df_d;

    logic [GRID_W-1:0] grid_shift;
    logic [ROWS-1:0]   row_full;
    logic [ROWS-1:0]   shift_full;
    logic              idle;
    logic              lock_ready;
    logic              handshake;
    logic [15:0]       points;
    logic [16:0]       score_sum;

    function automatic logic [15:0] clear_points(input logic [CW-1:0] n);
        case (n)
            CW'(0):  return 16'd0;
            CW'(1):  return 16'd1;
            CW'(2):  return 16'd3;
            CW'(3):  return 16'd5;
            default: return 16'd8;
        endcase
    endfunction

    // grid_shift is the playfield with row_q removed and everything above it dropped by one.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            localparam logic [RW-1:0] GI = RW'(gi);
            assign row_full[gi] = &grid_q[gi*COLS +: COLS];
            if (gi == 0) begin : g_top
                assign grid_shift[COLS-1:0] = '0;
            end else begin : g_body
                assign grid_shift[gi*COLS +: COLS] = (GI <= row_q) ? grid_q[(gi-1)*COLS +: COLS]
                                                                   : grid_q[gi*COLS +: COLS];
            end
            assign shift_full[gi] = &grid_shift[gi*COLS +: COLS];
        end
    endgenerate

    assign idle       = (state_q == S_IDLE);
    assign lock_ready = idle && !go_q;
    assign handshake  = bus.lock_valid && lock_ready;

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        mask_d    = mask_q;
        swap_d    = swap_q;
        row_d     = row_q;
        clr_d     = clr_q;
        lines_d   = lines_q;
        score_d   = score_q;
        go_d      = go_q;
        df_d      = bus.frame_end;
        points    = clear_points(clr_q);
        score_sum = {1'b0, score_q} + {1'b0, points};

        // While busy the storage stage keeps seeing the last consistent frame.
        if (bus.frame_end && idle) begin
            swap_d = grid_q | bus.piece_mask;
        end

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    mask_d = bus.lock_mask;
                    if ((grid_q & bus.lock_mask) != '0) begin
                        go_d = 1'b1;
                    end else begin
                        state_d = S_MERGE;
                    end
                end
            end
            S_MERGE: begin
                grid_d  = grid_q | mask_q;
                row_d   = LAST_ROW;
                clr_d   = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (row_full[row_q]) begin
                    state_d = S_SHIFT;
                end else if (row_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    row_d = row_q - RW'(1);
                end
            end
            S_SHIFT: begin
                // The recheck of the same row is folded in here, so each clear costs one cycle.
                grid_d = grid_shift;
                clr_d  = clr_q + CW'(1);
                if (shift_full[row_q]) begin
                    state_d = S_SHIFT;
                end else if (row_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q - RW'(1);
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                lines_d = (clr_q > CW'(15)) ? 4'hF : clr_q[3:0];
                score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                if (grid_q[COLS-1:0] != '0) begin
                    go_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grid_q  <= '0;
            mask_q  <= '0;
            swap_q  <= '0;
            row_q   <= '0;
            clr_q   <= '0;
            lines_q <= '0;
            score_q <= '0;
            go_q    <= 1'b0;
            df_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            mask_q  <= mask_d;
            swap_q  <= swap_d;
            row_q   <= row_d;
            clr_q   <= clr_d;
            lines_q <= lines_d;
            score_q <= score_d;
            go_q    <= go_d;
            df_q    <= df_d;
        end
    end

    assign bus.lock_ready    = lock_ready;
    assign bus.busy          = !idle;
    assign bus.data_swap     = swap_q;
    assign bus.draw_finish   = df_q;
    assign bus.lines_cleared = lines_q;
    assign bus.score         = score_q;
    assign bus.game_over     = go_q;
endmodule

// File: tb/tb_tetris_grid_builder.sv
// Bench for tetris_grid_builder: directed lock/frame scenarios, a per-cycle comparison
// against a row-compaction model, and literal expectations for the key scenarios.
module tb_tetris_grid_builder;
    localparam int COLS = 8;
    localparam int ROWS = 18;
    localparam int GW   = COLS * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tetris_grid_builder_if #(.COLS(COLS), .ROWS(ROWS)) bus ();
    tetris_grid_builder #(.COLS(COLS), .ROWS(ROWS)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: full rows are dropped and survivors packed to the bottom in order.
    function automatic logic [GW-1:0] settle(input logic [GW-1:0] g);
        logic [GW-1:0]   r;
        logic [COLS-1:0] rv;
        int              w;
        r = '0;
        w = ROWS - 1;
        for (int y = ROWS - 1; y >= 0; y--) begin
            rv = g[y*COLS +: COLS];
            if (rv != {COLS{1'b1}}) begin
                r[w*COLS +: COLS] = rv;
                w--;
            end
        end
        return r;
    endfunction

    function automatic int count_full(input logic [GW-1:0] g);
        int n;
        n = 0;
        for (int y = 0; y < ROWS; y++)
            if (g[y*COLS +: COLS] == {COLS{1'b1}}) n++;
        return n;
    endfunction

    function automatic int line_points(input int n);
        case (n)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 5;
            default: return 8;
        endcase
    endfunction

    logic [GW-1:0] m_grid, m_result, m_swap, m_merged;
    int            m_busy, m_n, m_sum;
    logic [3:0]    m_lines, m_pend_lines;
    logic [15:0]   m_score, m_pend_score;
    logic          m_go, m_df;

    assign m_merged = m_grid | bus.lock_mask;
    assign m_n      = count_full(m_merged);
    assign m_sum    = int'(m_score) + line_points(m_n);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_grid <= '0; m_result <= '0; m_swap <= '0; m_busy <= 0;
            m_lines <= '0; m_pend_lines <= '0; m_score <= '0; m_pend_score <= '0;
            m_go <= 1'b0; m_df <= 1'b0;
        end else begin
            m_df <= bus.frame_end;
            if (bus.frame_end && m_busy == 0) m_swap <= m_grid | bus.piece_mask;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_grid  <= m_result;
                    m_lines <= m_pend_lines;
                    m_score <= m_pend_score;
                    if (m_result[COLS-1:0] != '0) m_go <= 1'b1;
                end
            end else if (bus.lock_valid && !m_go) begin
                if ((m_grid & bus.lock_mask) != '0) begin
                    m_go <= 1'b1;
                end else begin
                    m_result     <= settle(m_merged);
                    m_busy       <= 20 + m_n;
                    m_pend_lines <= 4'(m_n);
                    m_pend_score <= (m_sum > 65535) ? 16'hFFFF : 16'(m_sum);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("lock_ready", bus.lock_ready, (m_busy == 0) && !m_go);
        check("busy", bus.busy, m_busy != 0);
        check("draw_finish", bus.draw_finish, m_df);
        check("data_swap", bus.data_swap, m_swap);
        check("lines_cleared", bus.lines_cleared, m_lines);
        check("score", bus.score, m_score);
        check("game_over", bus.game_over, m_go);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        $display("reset applied");
    endtask

    task automatic publish(input logic [GW-1:0] piece, output logic [GW-1:0] img);
        bus.piece_mask = piece;
        bus.frame_end  = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        check("publish_strobe", bus.draw_finish, 1'b1);
        img = bus.data_swap;
        tick();
        check("strobe_drop", bus.draw_finish, 1'b0);
        $display("frame publish piece=%0h image=%0h", piece, img);
    endtask

    // fe_hs pulses frame_end on the handshake edge; fe_at pulses it on that busy cycle's edge.
    task automatic do_lock(input logic [GW-1:0] mask, input bit fe_hs, input int fe_at, output int n);
        int guard;
        guard = 0;
        bus.lock_mask  = mask;
        bus.lock_valid = 1'b1;
        while (!bus.lock_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("lock_wait", bus.lock_ready, 1'b1);
        bus.frame_end = fe_hs;
        tick();
        bus.lock_valid = 1'b0;
        bus.frame_end  = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            bus.frame_end = (n == fe_at);
            tick();
            n++;
        end
        bus.frame_end = 1'b0;
        $display("lock mask=%0h busy_cycles=%0d lines=%0d score=%0d game_over=%0d",
                 mask, n, bus.lines_cleared, bus.score, bus.game_over);
    endtask

    initial begin
        logic [GW-1:0] img, m14, ivert;
        int n;
        bus.lock_valid = 1'b0;
        bus.lock_mask  = '0;
        bus.piece_mask = '0;
        bus.frame_end  = 1'b0;
        #1;
        do_reset();

        // Reset state and first publish
        check("rst_ready", bus.lock_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_swap", bus.data_swap, '0);
        check("rst_score", bus.score, 16'd0);
        check("rst_go", bus.game_over, 1'b0);
        publish(144'h1, img);
        check("t1_image", img, 144'h1);

        // Partial bottom row, frame_end on the handshake edge shows the pre-merge grid
        bus.piece_mask = 144'h4;
        do_lock(144'hF << 136, 1'b1, -1, n);
        check("t2_busy", n, 20);
        check("t2_swap_premerge", bus.data_swap, 144'h4);
        check("t2_lines", bus.lines_cleared, 4'd0);
        check("t2_score", bus.score, 16'd0);
        publish('0, img);
        check("t2_grid", img, 144'hF << 136);

        // One-line clear, frame_end on the DONE edge holds the old image
        do_lock(144'h3 << 140, 1'b0, -1, n);
        check("t3_fill_busy", n, 20);
        bus.piece_mask = 144'h1 << 5;
        do_lock((144'h3 << 142) | (144'h1 << 128), 1'b0, 20, n);
        check("t3_busy", n, 21);
        check("t3_lines", bus.lines_cleared, 4'd1);
        check("t3_score", bus.score, 16'd1);
        check("t3_swap_held", bus.data_swap, 144'hF << 136);
        publish('0, img);
        check("t3_grid", img, 144'h1 << 136);

        // Four-line clear with a vertical I
        do_reset();
        m14 = '0;
        ivert = '0;
        for (int y = 14; y < 18; y++) begin
            for (int x = 0; x < 7; x++) m14[x + COLS*y] = 1'b1;
            ivert[7 + COLS*y] = 1'b1;
        end
        do_lock(m14, 1'b0, -1, n);
        check("t4_build_busy", n, 20);
        do_lock(ivert, 1'b0, -1, n);
        check("t4_busy", n, 24);
        check("t4_lines", bus.lines_cleared, 4'd4);
        check("t4_score", bus.score, 16'd8);
        publish('0, img);
        check("t4_grid", img, '0);

        // Publish while busy, then asynchronous reset mid-scan with the strobe high
        publish(144'h1 << 5, img);
        check("t6_idle_image", img, 144'h1 << 5);
        bus.piece_mask = 144'h1 << 9;
        bus.lock_mask  = 144'h1 << 140;
        bus.lock_valid = 1'b1;
        tick();
        bus.lock_valid = 1'b0;
        tick();
        tick();
        tick();
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        check("t6_busy_strobe", bus.draw_finish, 1'b1);
        check("t6_busy_held", bus.data_swap, 144'h1 << 5);
        check("t6_busy_flag", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_strobe", bus.draw_finish, 1'b0);
        check("t6_rst_busy", bus.busy, 1'b0);
        check("t6_rst_swap", bus.data_swap, '0);
        check("t6_rst_score", bus.score, 16'd0);
        $display("async reset during scan");
        tick();
        rst = 1'b0;
        publish('0, img);
        check("t6_grid_discarded", img, '0);

        // Overlapping lock ends the game and blocks further locks
        do_lock(144'h1 << 136, 1'b0, -1, n);
        check("t5_busy", n, 20);
        bus.lock_mask  = 144'h3 << 136;
        bus.lock_valid = 1'b1;
        tick();
        check("t5_go", bus.game_over, 1'b1);
        check("t5_busy_flag", bus.busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t5_ready_low", bus.lock_ready, 1'b0);
            tick();
        end
        bus.lock_valid = 1'b0;
        $display("overlap lock game_over=%0d", bus.game_over);
        publish(144'h1 << 7, img);
        check("t5_grid_kept", img, (144'h1 << 136) | (144'h1 << 7));

        // A piece left in the top row ends the game at DONE
        do_reset();
        do_lock(144'h1 << 3, 1'b0, -1, n);
        check("t7_busy", n, 20);
        check("t7_go", bus.game_over, 1'b1);
        check("t7_ready", bus.lock_ready, 1'b0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
